// File: rtl/gpc_4t_pkg.sv
// Shared gpc_4t definitions: CR word offsets, boot-controller
// state and status encodings.
package gpc_4t_pkg;

   // Byte offsets of the CR words, relative to the CR base.
   // The d_mem_wrap decode uses the same offsets.
   localparam logic [31:0] CR_OFF_EN_PC  = 32'h0000_0000;
   localparam logic [31:0] CR_OFF_RST_PC = 32'h0000_0004;
   localparam logic [31:0] CR_OFF_RD_PTR = 32'h0000_0008;
   localparam logic [31:0] CR_OFF_START  = 32'h0000_0010;
   localparam logic [31:0] CR_OFF_DONE   = 32'h0000_0014;

   typedef enum logic [3:0] {
      S_IDLE,
      S_W_RST1,
      S_W_RDPTR,
      S_W_EN1,
      S_W_RST0,
      S_W_START,
      S_POLL_RD,
      S_POLL_CHK,
      S_POLL_WAIT,
      S_W_DONE0,
      S_W_EN0_OK,
      S_W_EN0_ERR,
      S_FIN
   } t_boot_state;

   typedef enum logic [1:0] {
      ST_NONE    = 2'd0,
      ST_OK      = 2'd1,
      ST_TIMEOUT = 2'd2,
      ST_ABORT   = 2'd3
   } t_boot_status;

   // Abort is honoured only before the completion writes begin.
   function automatic logic is_abortable(input t_boot_state s);
      return s inside {S_W_RST1, S_W_RDPTR, S_W_EN1,
                       S_W_RST0, S_W_START, S_POLL_RD,
                       S_POLL_CHK, S_POLL_WAIT};
   endfunction

endpackage

// File: rtl/mmio_boot_timer.sv
// Gap counter between done polls plus saturating poll timeout counter.
// Ports: i_clk, i_rst (sync, active-high), i_gap_clr/i_gap_en,
//        i_tmo_clr/i_tmo_en, o_gap_expired, o_timeout_hit.
module mmio_boot_timer
   import gpc_4t_pkg::*;
#(
   parameter int unsigned POLL_GAP = 16,
   parameter int unsigned TIMEOUT  = 100000,
   localparam int unsigned TW = $clog2(TIMEOUT + 1),
   localparam int unsigned GW = $clog2(POLL_GAP + 1)
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_gap_clr,
   input  logic i_gap_en,
   input  logic i_tmo_clr,
   input  logic i_tmo_en,
   output logic o_gap_expired,
   output logic o_timeout_hit
);

   logic [GW-1:0] r_gap;
   logic [TW-1:0] r_tmo;
   logic          w_gap_last;
   logic          w_tmo_sat;

   // The last wait cycle is the one where the count reads POLL_GAP-1,
   // giving exactly POLL_GAP wait cycles after a clear.
   assign w_gap_last = (r_gap == GW'(POLL_GAP - 1));
   assign w_tmo_sat  = (r_tmo == TW'(TIMEOUT));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_gap <= '0;
      end else if (i_gap_clr) begin
         r_gap <= '0;
      end else if (i_gap_en && !w_gap_last) begin
         r_gap <= r_gap + GW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tmo <= '0;
      end else if (i_tmo_clr) begin
         r_tmo <= '0;
      end else if (i_tmo_en && !w_tmo_sat) begin
         r_tmo <= r_tmo + TW'(1);
      end
   end

   assign o_gap_expired = w_gap_last;
   assign o_timeout_hit = w_tmo_sat;

endmodule

// File: rtl/mmio_boot_ctrl.sv
// SOC-side MMIO initiator that boots a gpc_4t core through its CR block.
// Ports: clock, rst (sync, active-high), go, rd_ptr_val, abort in;
//        busy, done_pulse, status out; m_* d_mem master port, m_q in.
module mmio_boot_ctrl
   import gpc_4t_pkg::*;
#(
   parameter logic [31:0] CSR_BASE = 32'h0000_1C00,
   parameter int unsigned POLL_GAP = 16,
   parameter int unsigned TIMEOUT  = 100000
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        go,
   input  logic [4:0]  rd_ptr_val,
   input  logic        abort,
   output logic        busy,
   output logic        done_pulse,
   output logic [1:0]  status,
   output logic [31:0] m_address,
   output logic [3:0]  m_byteena,
   output logic [31:0] m_data,
   output logic        m_rden,
   output logic        m_wren,
   input  logic [31:0] m_q
);

   t_boot_state  r_state;
   t_boot_status r_status;
   logic [4:0]   r_rd_ptr;

   t_boot_state  w_nxt;
   t_boot_status w_stat_nxt;
   logic         w_go_ok;
   logic         w_rden;
   logic         w_wren;
   logic [31:0]  w_addr;
   logic [31:0]  w_wdata;
   logic         w_gap_clr;
   logic         w_gap_en;
   logic         w_tmo_clr;
   logic         w_tmo_en;
   logic         w_gap_exp;
   logic         w_tmo_hit;
   logic         w_unused;

   // Only bit 0 of the done word carries information.
   assign w_unused = ^m_q[31:1];

   assign w_go_ok = (r_state == S_IDLE) && go;

   mmio_boot_timer #(
      .POLL_GAP (POLL_GAP),
      .TIMEOUT  (TIMEOUT)
   ) u_timer (
      .i_clk         (clock),
      .i_rst         (rst),
      .i_gap_clr     (w_gap_clr),
      .i_gap_en      (w_gap_en),
      .i_tmo_clr     (w_tmo_clr),
      .i_tmo_en      (w_tmo_en),
      .o_gap_expired (w_gap_exp),
      .o_timeout_hit (w_tmo_hit)
   );

   always_ff @(posedge clock) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_status <= ST_NONE;
         r_rd_ptr <= '0;
      end else begin
         r_state  <= w_nxt;
         r_status <= w_stat_nxt;
         if (w_go_ok) begin
            r_rd_ptr <= rd_ptr_val;
         end
      end
   end

   always_comb begin
      w_nxt      = r_state;
      w_stat_nxt = r_status;
      w_rden     = 1'b0;
      w_wren     = 1'b0;
      w_addr     = '0;
      w_wdata    = '0;
      w_gap_clr  = 1'b0;
      w_gap_en   = 1'b0;
      w_tmo_clr  = 1'b0;
      w_tmo_en   = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (go) begin
               w_nxt      = S_W_RST1;
               w_stat_nxt = ST_NONE;
               w_tmo_clr  = 1'b1;
            end
         end
         S_W_RST1: begin
            w_wren  = 1'b1;
            w_addr  = CSR_BASE + CR_OFF_RST_PC;
            w_wdata = 32'd1;
            w_nxt   = S_W_RDPTR;
         end
         S_W_RDPTR: begin
            w_wren  = 1'b1;
            w_addr  = CSR_BASE + CR_OFF_RD_PTR;
            w_wdata = {27'd0, r_rd_ptr};
            w_nxt   = S_W_EN1;
         end
         S_W_EN1: begin
            w_wren  = 1'b1;
            w_addr  = CSR_BASE + CR_OFF_EN_PC;
            w_wdata = 32'd1;
            w_nxt   = S_W_RST0;
         end
         S_W_RST0: begin
            w_wren  = 1'b1;
            w_addr  = CSR_BASE + CR_OFF_RST_PC;
            w_wdata = 32'd0;
            w_nxt   = S_W_START;
         end
         S_W_START: begin
            w_wren  = 1'b1;
            w_addr  = CSR_BASE + CR_OFF_START;
            w_wdata = 32'd1;
            w_nxt   = S_POLL_RD;
         end
         S_POLL_RD: begin
            w_rden   = 1'b1;
            w_addr   = CSR_BASE + CR_OFF_DONE;
            w_tmo_en = 1'b1;
            w_nxt    = S_POLL_CHK;
         end
         S_POLL_CHK: begin
            w_tmo_en = 1'b1;
            // Done is tested first so it wins a tie with the timeout.
            if (m_q[0]) begin
               w_nxt = S_W_DONE0;
            end else if (w_tmo_hit) begin
               w_nxt      = S_W_EN0_ERR;
               w_stat_nxt = ST_TIMEOUT;
            end else begin
               w_nxt     = S_POLL_WAIT;
               w_gap_clr = 1'b1;
            end
         end
         S_POLL_WAIT: begin
            w_tmo_en = 1'b1;
            w_gap_en = 1'b1;
            if (w_tmo_hit) begin
               w_nxt      = S_W_EN0_ERR;
               w_stat_nxt = ST_TIMEOUT;
            end else if (w_gap_exp) begin
               w_nxt = S_POLL_RD;
            end
         end
         S_W_DONE0: begin
            w_wren  = 1'b1;
            w_addr  = CSR_BASE + CR_OFF_DONE;
            w_wdata = 32'd0;
            w_nxt   = S_W_EN0_OK;
         end
         S_W_EN0_OK: begin
            w_wren     = 1'b1;
            w_addr     = CSR_BASE + CR_OFF_EN_PC;
            w_wdata    = 32'd0;
            w_stat_nxt = ST_OK;
            w_nxt      = S_FIN;
         end
         S_W_EN0_ERR: begin
            w_wren  = 1'b1;
            w_addr  = CSR_BASE + CR_OFF_EN_PC;
            w_wdata = 32'd0;
            w_nxt   = S_FIN;
         end
         S_FIN: begin
            w_nxt = S_IDLE;
         end
         default: begin
            w_nxt = S_IDLE;
         end
      endcase

      // Abort overrides every decision above, including a poll result.
      if (abort && is_abortable(r_state)) begin
         w_nxt      = S_W_EN0_ERR;
         w_stat_nxt = ST_ABORT;
      end
   end

   // Strobes are suppressed in any cycle that reset is asserted,
   // so a mid-run reset never leaks a partial transaction.
   assign m_rden     = w_rden & ~rst;
   assign m_wren     = w_wren & ~rst;
   assign m_address  = rst ? '0 : w_addr;
   assign m_data     = rst ? '0 : w_wdata;
   assign m_byteena  = (m_rden | m_wren) ? 4'hF : 4'h0;
   assign busy       = ~rst && (r_state != S_IDLE)
                            && (r_state != S_FIN);
   assign done_pulse = ~rst && (r_state == S_FIN);
   assign status     = r_status;

endmodule

// File: tb/tb_mmio_boot_ctrl.sv
// Scoreboard bench for mmio_boot_ctrl: a timeline model queues the
// expected bus/done events per run, a negedge monitor checks them.
module tb_mmio_boot_ctrl;

   localparam int GAP = 4;
   localparam int TMO = 19;

   localparam logic [31:0] A_EN  = 32'h0000_1C00;
   localparam logic [31:0] A_RST = 32'h0000_1C04;
   localparam logic [31:0] A_RDP = 32'h0000_1C08;
   localparam logic [31:0] A_ST  = 32'h0000_1C10;
   localparam logic [31:0] A_DN  = 32'h0000_1C14;

   localparam int K_RD = 0;
   localparam int K_WR = 1;
   localparam int K_DN = 2;

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
   } ev_t;

   logic        clock;
   logic        rst;
   logic        go;
   logic [4:0]  rd_ptr_val;
   logic        abort;
   logic        busy;
   logic        done_pulse;
   logic [1:0]  status;
   logic [31:0] m_address;
   logic [3:0]  m_byteena;
   logic [31:0] m_data;
   logic        m_rden;
   logic        m_wren;
   logic [31:0] m_q;

   int  cyc = 0;
   int  n_cmp = 0;
   int  n_bad = 0;
   int  rd_total = 0;
   int  done_abs = 0;
   ev_t exp_q[$];

   mmio_boot_ctrl #(
      .CSR_BASE (32'h0000_1C00),
      .POLL_GAP (GAP),
      .TIMEOUT  (TMO)
   ) dut (
      .clock      (clock),
      .rst        (rst),
      .go         (go),
      .rd_ptr_val (rd_ptr_val),
      .abort      (abort),
      .busy       (busy),
      .done_pulse (done_pulse),
      .status     (status),
      .m_address  (m_address),
      .m_byteena  (m_byteena),
      .m_data     (m_data),
      .m_rden     (m_rden),
      .m_wren     (m_wren),
      .m_q        (m_q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Memory responder: done bit reads 1 from read number done_abs on.
   always @(posedge clock) begin
      if (m_rden) begin
         rd_total <= rd_total + 1;
         m_q <= ($urandom & 32'hFFFF_FFFE)
              | {31'd0, rd_total >= done_abs};
      end else begin
         m_q <= $urandom;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
      end
   endtask

   task automatic fail(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
      n_cmp++;
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
   endtask

   // Monitor: sample outputs mid-cycle and pop matching expectations.
   always @(negedge clock) begin
      ev_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         fail("missing_event", 32'hFFFF_FFFF, exp_q[0].addr);
         void'(exp_q.pop_front());
      end
      chk("one_strobe", {31'd0, m_rden & m_wren}, 32'd0);
      if (m_rden || m_wren) begin
         if (exp_q.size() == 0 || exp_q[0].cyc != cyc
             || exp_q[0].kind == K_DN) begin
            fail("unexpected_strobe", m_address, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("bus_kind", {31'd0, m_wren}, e.kind);
            chk("bus_addr", m_address, e.addr);
            chk("bus_data", m_data, e.data);
            chk("bus_be", {28'd0, m_byteena}, 32'hF);
         end
      end else begin
         chk("idle_bus", m_address | m_data | {28'd0, m_byteena}, 32'd0);
      end
      if (done_pulse) begin
         if (exp_q.size() == 0 || exp_q[0].cyc != cyc
             || exp_q[0].kind != K_DN) begin
            fail("unexpected_done", {30'd0, status}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("done_status", {30'd0, status}, e.data);
            chk("fin_busy", {31'd0, busy}, 32'd0);
         end
      end
   end

   function automatic void push(int c0, int off, int rs, int kind,
                                logic [31:0] a, logic [31:0] d);
      if (rs == 0 || off < rs) exp_q.push_back('{c0 + off, kind, a, d});
   endfunction

   // Shutdown after abort/timeout decided in the cycle at offset o.
   function automatic int term(int c0, int rs, int o, int stv);
      push(c0, o + 1, rs, K_WR, A_EN, 32'd0);
      push(c0, o + 2, rs, K_DN, 32'd0, stv);
      return o + 2;
   endfunction

   // Timeline model. Offset k is the k-th cycle after the go cycle.
   // t counts cycles since the first poll read, which is the
   // timeout measure (give up once t >= TMO at a check/wait cycle).
   task automatic build(input logic [4:0] rdp, input int done_at,
                        input int ab, input int rs, input int c0,
                        output int fin, output int st);
      logic [31:0] sa[5];
      logic [31:0] sd[5];
      int t;
      int n;
      sa = '{A_RST, A_RDP, A_EN, A_RST, A_ST};
      sd = '{32'd1, {27'd0, rdp}, 32'd1, 32'd0, 32'd1};
      fin = 0;
      st  = 0;
      for (int i = 1; i <= 5 && fin == 0; i++) begin
         push(c0, i, rs, K_WR, sa[i-1], sd[i-1]);
         if (ab == i) begin fin = term(c0, rs, i, 3); st = 3; end
      end
      t = 0;
      n = 0;
      while (fin == 0) begin
         push(c0, 6 + t, rs, K_RD, A_DN, 32'd0);
         if (ab == 6 + t) begin
            fin = term(c0, rs, 6 + t, 3); st = 3;
         end else begin
            t++;
            if (ab == 6 + t) begin
               fin = term(c0, rs, 6 + t, 3); st = 3;
            end else if (n == done_at) begin
               push(c0, 7 + t, rs, K_WR, A_DN, 32'd0);
               push(c0, 8 + t, rs, K_WR, A_EN, 32'd0);
               push(c0, 9 + t, rs, K_DN, 32'd0, 32'd1);
               fin = 9 + t; st = 1;
            end else if (t >= TMO) begin
               fin = term(c0, rs, 6 + t, 2); st = 2;
            end else begin
               n++;
               for (int g = 0; g < GAP && fin == 0; g++) begin
                  t++;
                  if (ab == 6 + t) begin
                     fin = term(c0, rs, 6 + t, 3); st = 3;
                  end else if (t >= TMO) begin
                     fin = term(c0, rs, 6 + t, 2); st = 2;
                  end
               end
               t++;
            end
         end
      end
      if (rs != 0) begin fin = rs; st = 0; end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic run(input logic [4:0] rdp, input int done_at,
                      input int ab, input int g2, input int rs);
      int c0;
      int fin;
      int st;
      c0 = cyc;
      build(rdp, done_at, ab, rs, c0, fin, st);
      if (g2 > fin || (rs != 0 && g2 >= rs)) g2 = 0;
      done_abs = rd_total + done_at;
      go = 1'b1;
      rd_ptr_val = rdp;
      for (int k = 1; k <= fin + 1; k++) begin
         tick();
         go = (k == g2);
         rd_ptr_val = 5'($urandom);
         abort = (k == ab);
         rst = (k == rs);
      end
      tick();
      go = 1'b0;
      abort = 1'b0;
      rst = 1'b0;
      chk("end_status", {30'd0, status}, st);
      chk("end_busy", {31'd0, busy}, 32'd0);
      chk("queue_drained", exp_q.size(), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      go = 1'b0;
      abort = 1'b0;
      rd_ptr_val = '0;
      repeat (3) tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done_pulse}, 32'd0);
      chk("rst_status", {30'd0, status}, 32'd0);
      chk("rst_strobe", {31'd0, m_rden | m_wren}, 32'd0);
      rst = 1'b0;
      repeat (2) tick();

      run(5'd3, 0, 0, 0, 0);
      run(5'($urandom), 2, 0, 0, 0);
      run(5'($urandom), 1000, 0, 0, 0);
      run(5'($urandom), 1000, 9, 0, 0);

      abort = 1'b1;
      repeat (5) tick();
      abort = 1'b0;
      chk("idle_abort_busy", {31'd0, busy}, 32'd0);

      run(5'($urandom), 0, 0, 2, 3);
      run(5'($urandom), 0, 0, 0, 0);
      run(5'($urandom), 3, 0, 0, 0);

      for (int r = 0; r < 40; r++) begin
         run(5'($urandom), int'($urandom_range(0, 4)),
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 32)) : 0,
             int'($urandom_range(0, 12)), 0);
         repeat (int'($urandom_range(0, 3))) tick();
      end

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
